// File: rtl/hazard_unit.sv
// Execute-stage pipeline controller: tracks in-flight destinations, registers the
// operand-forwarding selects, and sequences load-use stalls, branch flushes and freezes.
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_we_i,
    input  logic             id_is_load_i,
    input  logic             ex_br_taken_i,
    input  logic             mem_ready_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic             bubble_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } ex_slot_t;

    // MEM only needs to be matched, not tested for load. WB is not tracked at all:
    // the regfile is write-first, so a WB producer is already visible to ID.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
    } mem_slot_t;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_FREEZE,
        MODE_FLUSH,
        MODE_STALL
    } mode_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    ex_slot_t  ex_slot;
    mem_slot_t mem_slot;
    mode_t     mode;
    logic      load_use;
    logic      issue;
    logic      ex_hit_rs1;
    logic      ex_hit_rs2;
    logic      mem_hit_rs1;
    logic      mem_hit_rs2;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    // x0 never matches, so it can neither stall nor forward.
    assign ex_hit_rs1  = (id_rs1_i != 5'd0) && ex_slot.valid  && ex_slot.we  && (ex_slot.rd  == id_rs1_i);
    assign ex_hit_rs2  = (id_rs2_i != 5'd0) && ex_slot.valid  && ex_slot.we  && (ex_slot.rd  == id_rs2_i);
    assign mem_hit_rs1 = (id_rs1_i != 5'd0) && mem_slot.valid && mem_slot.we && (mem_slot.rd == id_rs1_i);
    assign mem_hit_rs2 = (id_rs2_i != 5'd0) && mem_slot.valid && mem_slot.we && (mem_slot.rd == id_rs2_i);

    assign load_use = id_valid_i && ex_slot.is_load &&
                      ((id_use_rs1_i && ex_hit_rs1) || (id_use_rs2_i && ex_hit_rs2));

    always_comb begin
        mode = MODE_RUN;
        if (!mem_ready_i) begin
            mode = MODE_FREEZE;
        end else if (ex_br_taken_i) begin
            mode = MODE_FLUSH;
        end else if (load_use) begin
            mode = MODE_STALL;
        end
    end

    always_comb begin
        stall_o  = 1'b0;
        flush_o  = 1'b0;
        bubble_o = 1'b0;
        if (rst_ni) begin
            case (mode)
                MODE_FREEZE: stall_o = 1'b1;
                MODE_FLUSH: begin
                    flush_o  = 1'b1;
                    bubble_o = 1'b1;
                end
                MODE_STALL: begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign issue = id_valid_i && (mode == MODE_RUN);

    // EX producer (about to reach MEM) wins over an older MEM producer.
    always_comb begin
        fwd_a_next = FWD_RF;
        fwd_b_next = FWD_RF;
        if (issue) begin
            if (id_use_rs1_i && ex_hit_rs1) begin
                fwd_a_next = FWD_MEM;
            end else if (id_use_rs1_i && mem_hit_rs1) begin
                fwd_a_next = FWD_WB;
            end
            if (id_use_rs2_i && ex_hit_rs2) begin
                fwd_b_next = FWD_MEM;
            end else if (id_use_rs2_i && mem_hit_rs2) begin
                fwd_b_next = FWD_WB;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_slot     <= '0;
            mem_slot    <= '0;
            fwd_a_o     <= FWD_RF;
            fwd_b_o     <= FWD_RF;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (mem_ready_i) begin
                mem_slot.valid <= ex_slot.valid;
                mem_slot.rd    <= ex_slot.rd;
                mem_slot.we    <= ex_slot.we;
                if (issue) begin
                    ex_slot.valid   <= 1'b1;
                    ex_slot.rd      <= id_rd_i;
                    ex_slot.we      <= id_we_i;
                    ex_slot.is_load <= id_is_load_i;
                end else begin
                    ex_slot <= '0;
                end
                fwd_a_o <= fwd_a_next;
                fwd_b_o <= fwd_b_next;
            end
            if (stall_o && !flush_o) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (flush_o) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed instruction sequences, with expected
// forwarding selects queued at issue and compared once the consumer sits in EX.
module tb_hazard_unit;

    localparam int CNT_W = 32;

    logic             clk_i;
    logic             rst_ni;
    logic             id_valid_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_use_rs1_i;
    logic             id_use_rs2_i;
    logic [4:0]       id_rd_i;
    logic             id_we_i;
    logic             id_is_load_i;
    logic             ex_br_taken_i;
    logic             mem_ready_i;
    logic             stall_o;
    logic             flush_o;
    logic             bubble_o;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    int tests_run;
    int tests_failed;
    logic [3:0] exp_q[$];
    logic [3:0] exp_fwd;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .id_valid_i   (id_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .id_rd_i      (id_rd_i),
        .id_we_i      (id_we_i),
        .id_is_load_i (id_is_load_i),
        .ex_br_taken_i(ex_br_taken_i),
        .mem_ready_i  (mem_ready_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .bubble_o     (bubble_o),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // drivers
    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2, input logic [4:0] rd,
                            input logic we, input logic ld);
        id_valid_i   = v;
        id_rs1_i     = rs1;
        id_rs2_i     = rs2;
        id_use_rs1_i = u1;
        id_use_rs2_i = u2;
        id_rd_i      = rd;
        id_we_i      = we;
        id_is_load_i = ld;
        #1;
    endtask

    task automatic do_reset();
        rst_ni        = 1'b0;
        ex_br_taken_i = 1'b0;
        mem_ready_i   = 1'b1;
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        rst_ni = 1'b1;
        exp_q.delete();
        #1;
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        ex_br_taken_i = 1'b1;
        mem_ready_i   = 1'b0;
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
        tick();
        tests_run++;
        if ({stall_o, flush_o, bubble_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 000", {stall_o, flush_o, bubble_o});
        end
        tests_run++;
        if ({fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: fwd %b/%b cnt %0d/%0d want 0", fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o);
        end
        do_reset();
    endtask

    task automatic test_ex_forward();
        do_reset();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);  // addi x1,x0,5
        tick();
        drive_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add x3,x1,x1
        tests_run++;
        if ({stall_o, bubble_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL ex_fwd_nostall: stall/bubble %b want 00", {stall_o, bubble_o});
        end
        exp_q.push_back(4'b0101);
        tick();
        exp_fwd = exp_q.pop_front();
        tests_run++;
        if ({fwd_a_o, fwd_b_o} !== exp_fwd) begin
            tests_failed++;
            $display("FAIL ex_fwd: got %b want %b", {fwd_a_o, fwd_b_o}, exp_fwd);
        end
    endtask

    task automatic test_mem_forward();
        do_reset();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);  // addi x1
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);  // nop
        tick();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add x3,x1,x0
        exp_q.push_back(4'b1000);
        tick();
        exp_fwd = exp_q.pop_front();
        tests_run++;
        if ({fwd_a_o, fwd_b_o} !== exp_fwd) begin
            tests_failed++;
            $display("FAIL mem_fwd: got %b want %b", {fwd_a_o, fwd_b_o}, exp_fwd);
        end
        // both EX and MEM write x1: the younger one wins
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);  // addi x1
        tick();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);  // addi x1,x1,1
        exp_q.push_back(4'b0100);
        tick();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add x3,x1,x0
        exp_q.push_back(4'b0100);
        exp_fwd = exp_q.pop_front();
        tests_run++;
        if ({fwd_a_o, fwd_b_o} !== exp_fwd) begin
            tests_failed++;
            $display("FAIL chain_fwd: got %b want %b", {fwd_a_o, fwd_b_o}, exp_fwd);
        end
        tick();
        exp_fwd = exp_q.pop_front();
        tests_run++;
        if ({fwd_a_o, fwd_b_o} !== exp_fwd) begin
            tests_failed++;
            $display("FAIL prio_fwd: got %b want %b", {fwd_a_o, fwd_b_o}, exp_fwd);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);  // lw x5
        tick();
        drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // add x6,x5,x0
        tests_run++;
        if ({stall_o, flush_o, bubble_o} !== 3'b101) begin
            tests_failed++;
            $display("FAIL lu_stall: got %b want 101", {stall_o, flush_o, bubble_o});
        end
        tick();
        tests_run++;
        if ({stall_o, flush_o, bubble_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL lu_release: got %b want 000", {stall_o, flush_o, bubble_o});
        end
        tests_run++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL lu_bubble_fwd: got %b want 0000", {fwd_a_o, fwd_b_o});
        end
        exp_q.push_back(4'b1000);
        tick();
        exp_fwd = exp_q.pop_front();
        tests_run++;
        if ({fwd_a_o, fwd_b_o} !== exp_fwd) begin
            tests_failed++;
            $display("FAIL lu_fwd: got %b want %b", {fwd_a_o, fwd_b_o}, exp_fwd);
        end
        tests_run++;
        if (stall_cnt_o !== 32'd1) begin
            tests_failed++;
            $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt_o);
        end
    endtask

    task automatic test_x0();
        do_reset();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);  // addi x0,x0,1
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add x3,x0,x0
        exp_q.push_back(4'b0000);
        tick();
        exp_fwd = exp_q.pop_front();
        tests_run++;
        if ({fwd_a_o, fwd_b_o} !== exp_fwd) begin
            tests_failed++;
            $display("FAIL x0_fwd: got %b want %b", {fwd_a_o, fwd_b_o}, exp_fwd);
        end
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // lw x0
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // add x6,x0,x0
        tests_run++;
        if ({stall_o, bubble_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL x0_load_nostall: got %b want 00", {stall_o, bubble_o});
        end
        tick();
        tests_run++;
        if (stall_cnt_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL x0_stall_cnt: got %0d want 0", stall_cnt_o);
        end
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);  // lw x5
        tick();
        drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // add x6,x5,x0
        ex_br_taken_i = 1'b1;
        #1;
        tests_run++;
        if ({stall_o, flush_o, bubble_o} !== 3'b011) begin
            tests_failed++;
            $display("FAIL br_ctrl: got %b want 011", {stall_o, flush_o, bubble_o});
        end
        tick();
        ex_br_taken_i = 1'b0;
        #1;
        // the discarded add must not be in EX, and the lw has moved on to MEM
        tests_run++;
        if ({stall_o, flush_o, bubble_o, fwd_a_o, fwd_b_o} !== 7'b0000000) begin
            tests_failed++;
            $display("FAIL br_ex_invalid: ctrl %b fwd %b want 000/0000", {stall_o, flush_o, bubble_o}, {fwd_a_o, fwd_b_o});
        end
        tests_run++;
        if ({flush_cnt_o, stall_cnt_o} !== {32'd1, 32'd0}) begin
            tests_failed++;
            $display("FAIL br_cnt: flush %0d stall %0d want 1/0", flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_freeze_reset();
        do_reset();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);  // addi x1
        tick();
        drive_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add x3,x1,x1
        exp_q.push_back(4'b0101);
        tick();
        ex_br_taken_i = 1'b1;
        mem_ready_i   = 1'b0;
        drive_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({stall_o, flush_o, bubble_o} !== 3'b100) begin
                tests_failed++;
                $display("FAIL frz_ctrl[%0d]: got %b want 100", i, {stall_o, flush_o, bubble_o});
            end
            tick();
        end
        exp_fwd = exp_q.pop_front();
        tests_run++;
        if ({fwd_a_o, fwd_b_o} !== exp_fwd) begin
            tests_failed++;
            $display("FAIL frz_fwd_hold: got %b want %b", {fwd_a_o, fwd_b_o}, exp_fwd);
        end
        mem_ready_i = 1'b1;
        #1;
        tests_run++;
        if ({stall_o, flush_o, bubble_o} !== 3'b011) begin
            tests_failed++;
            $display("FAIL frz_release: got %b want 011", {stall_o, flush_o, bubble_o});
        end
        tests_run++;
        if (stall_cnt_o !== 32'd3) begin
            tests_failed++;
            $display("FAIL frz_stall_cnt: got %0d want 3", stall_cnt_o);
        end
        tick();
        ex_br_taken_i = 1'b0;
        tests_run++;
        if (flush_cnt_o !== 32'd1) begin
            tests_failed++;
            $display("FAIL frz_flush_cnt: got %0d want 1", flush_cnt_o);
        end
        // rebuild non-zero selects, freeze, then reset mid-freeze
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        mem_ready_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if ({fwd_a_o, fwd_b_o, stall_o, flush_o, bubble_o} !== 7'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_freeze: fwd %b ctrl %b want 0", {fwd_a_o, fwd_b_o}, {stall_o, flush_o, bubble_o});
        end
        tests_run++;
        if ({stall_cnt_o, flush_cnt_o} !== '0) begin
            tests_failed++;
            $display("FAIL rst_cnt: stall %0d flush %0d want 0/0", stall_cnt_o, flush_cnt_o);
        end
        do_reset();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_x0();
        test_branch_over_load_use();
        test_freeze_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
